// File: rtl/player_input_pkg.sv
// -----------------------------------------------------------------------------
// player_input_pkg
//   Shared definitions for the multi-player input controller:
//     - shoot_state_e : per-player shoot handshake state encoding
//     - SPEED_STOP    : speed value written by a stop press
//     - speed_value() : signed +/- magnitude, computed at 64 bits so the
//                       caller can truncate it to any DATA_WIDTH <= 64 and
//                       still get a correct two's-complement word.
// -----------------------------------------------------------------------------
package player_input_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_COOLDOWN = 2'd2
  } shoot_state_e;

  localparam logic signed [63:0] SPEED_STOP = '0;

  function automatic logic signed [63:0] speed_value(input logic neg, input int mag);
    logic signed [63:0] w_mag;
    w_mag = 64'(mag);
    return neg ? -w_mag : w_mag;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//   One raw asynchronous button -> 2-FF synchroniser -> debounce counter ->
//   registered single-cycle pulse on each accepted rising edge.
//   The debounced level flips only after DEBOUNCE_CYCLES consecutive cycles in
//   which the synchronised input disagrees with it; any agreeing cycle resets
//   the count. From the first clock edge that samples the button high, the
//   pulse is visible after edge DEBOUNCE_CYCLES+3.
// Ports
//   clock   in  system clock
//   reset   in  synchronous, active-high
//   i_btn   in  raw button level (asynchronous)
//   o_pulse out one-cycle pulse per debounced rising edge
// -----------------------------------------------------------------------------
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic             r_level_q;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  // NOTE: every register here is updated with non-blocking assignments so the
  // synchroniser stages shift by exactly one stage per edge regardless of
  // statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync    <= '0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_pulse   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};

      if (r_sync[1] != r_level) begin
        // Flip on the cycle that would complete the run of disagreeing samples.
        if (r_cnt == CNT_LAST) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end

      r_level_q <= r_level;
      r_pulse   <= r_level & ~r_level_q;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/player_input_controller.sv
// -----------------------------------------------------------------------------
// player_input_controller
//   Multi-player button front end for the game processor. Each player channel
//   debounces left/right/shoot/stop, keeps a signed speed word and runs a
//   shoot request/ack handshake followed by a cooldown period.
// Ports
//   clock      in  system clock, rising edge
//   reset      in  synchronous, active-high
//   enable     in  game running; low clears speed/FSM and ignores presses
//   btn_left   in  [NUM_PLAYERS]  raw button levels
//   btn_right  in  [NUM_PLAYERS]
//   btn_shoot  in  [NUM_PLAYERS]
//   btn_stop   in  [NUM_PLAYERS]
//   shoot_ack  in  [NUM_PLAYERS]  processor consumed the pending shot
//   speed_data out [NUM_PLAYERS*DATA_WIDTH] player p at [p*DATA_WIDTH +: DATA_WIDTH]
//   shoot_req  out [NUM_PLAYERS]  shot pending
//   cooling    out [NUM_PLAYERS]  channel is in cooldown
// -----------------------------------------------------------------------------
module player_input_controller
  import player_input_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int SPEED_MAG       = 1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COOLDOWN_CYCLES = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [NUM_PLAYERS-1:0]            btn_left,
  input  logic [NUM_PLAYERS-1:0]            btn_right,
  input  logic [NUM_PLAYERS-1:0]            btn_shoot,
  input  logic [NUM_PLAYERS-1:0]            btn_stop,
  input  logic [NUM_PLAYERS-1:0]            shoot_ack,
  output logic [NUM_PLAYERS*DATA_WIDTH-1:0] speed_data,
  output logic [NUM_PLAYERS-1:0]            shoot_req,
  output logic [NUM_PLAYERS-1:0]            cooling
);

  // A zero-length cooldown still needs a 1-bit counter to keep widths legal.
  localparam int               CD_W    = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
  localparam logic [CD_W-1:0]  CD_LOAD = CD_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);

  localparam logic [DATA_WIDTH-1:0] SPEED_ZERO  = DATA_WIDTH'(SPEED_STOP);
  localparam logic [DATA_WIDTH-1:0] SPEED_LEFT  = DATA_WIDTH'(speed_value(1'b1, SPEED_MAG));
  localparam logic [DATA_WIDTH-1:0] SPEED_RIGHT = DATA_WIDTH'(speed_value(1'b0, SPEED_MAG));

  logic [NUM_PLAYERS-1:0] w_left_p;
  logic [NUM_PLAYERS-1:0] w_right_p;
  logic [NUM_PLAYERS-1:0] w_shoot_p;
  logic [NUM_PLAYERS-1:0] w_stop_p;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
      .clock(clock), .reset(reset), .i_btn(btn_left[p]),  .o_pulse(w_left_p[p])
    );
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
      .clock(clock), .reset(reset), .i_btn(btn_right[p]), .o_pulse(w_right_p[p])
    );
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_shoot (
      .clock(clock), .reset(reset), .i_btn(btn_shoot[p]), .o_pulse(w_shoot_p[p])
    );
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
      .clock(clock), .reset(reset), .i_btn(btn_stop[p]),  .o_pulse(w_stop_p[p])
    );

    shoot_state_e          r_state;
    logic [CD_W-1:0]       r_cd_cnt;
    logic [DATA_WIDTH-1:0] r_speed;
    logic                  r_req;
    logic                  r_cool;

    always_ff @(posedge clock) begin
      // Dropping enable behaves like a reset of the channel state; the
      // debouncers are deliberately left running so a button already held
      // when the game starts does not fire.
      if (reset || !enable) begin
        r_state  <= ST_IDLE;
        r_cd_cnt <= '0;
        r_speed  <= SPEED_ZERO;
        r_req    <= 1'b0;
        r_cool   <= 1'b0;
      end else begin
        // Speed: stop dominates; simultaneous left+right is ambiguous and holds.
        if (w_stop_p[p]) begin
          r_speed <= SPEED_ZERO;
        end else if (w_left_p[p] && w_right_p[p]) begin
          r_speed <= r_speed;
        end else if (w_left_p[p]) begin
          r_speed <= SPEED_LEFT;
        end else if (w_right_p[p]) begin
          r_speed <= SPEED_RIGHT;
        end

        // Shoot handshake. Shoot presses outside IDLE are dropped, acks
        // outside ARMED are ignored.
        case (r_state)
          ST_IDLE: begin
            if (w_shoot_p[p] && !w_stop_p[p]) begin
              r_state <= ST_ARMED;
              r_req   <= 1'b1;
            end
          end
          ST_ARMED: begin
            // The processor already took the shot, so an ack beats a stop.
            if (shoot_ack[p]) begin
              r_req <= 1'b0;
              if (COOLDOWN_CYCLES > 0) begin
                r_state  <= ST_COOLDOWN;
                r_cd_cnt <= CD_LOAD;
                r_cool   <= 1'b1;
              end else begin
                r_state <= ST_IDLE;
              end
            end else if (w_stop_p[p]) begin
              r_state <= ST_IDLE;
              r_req   <= 1'b0;
            end
          end
          ST_COOLDOWN: begin
            if (r_cd_cnt == '0) begin
              r_state <= ST_IDLE;
              r_cool  <= 1'b0;
            end else begin
              r_cd_cnt <= r_cd_cnt - CD_W'(1);
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_cd_cnt <= '0;
            r_req    <= 1'b0;
            r_cool   <= 1'b0;
          end
        endcase
      end
    end

    assign speed_data[p*DATA_WIDTH +: DATA_WIDTH] = r_speed;
    assign shoot_req[p] = r_req;
    assign cooling[p]   = r_cool;

  end : g_player

endmodule

// File: tb/tb_player_input_controller.sv
// -----------------------------------------------------------------------------
// tb_player_input_controller
//   Directed bench for player_input_controller with the default parameters
//   (2 players, 32-bit speed, magnitude 1, debounce 4, cooldown 32).
//   Inputs change 1 time unit after a rising edge; outputs are read at the
//   same point, i.e. after the edge that produced them has settled.
// -----------------------------------------------------------------------------
module tb_player_input_controller;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [1:0]  btn_left;
  logic [1:0]  btn_right;
  logic [1:0]  btn_shoot;
  logic [1:0]  btn_stop;
  logic [1:0]  shoot_ack;
  logic [63:0] speed_data;
  logic [1:0]  shoot_req;
  logic [1:0]  cooling;

  int checks   = 0;
  int failures = 0;

  player_input_controller dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_shoot  (btn_shoot),
    .btn_stop   (btn_stop),
    .shoot_ack  (shoot_ack),
    .speed_data (speed_data),
    .shoot_req  (shoot_req),
    .cooling    (cooling)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    btn_left = '0; btn_right = '0; btn_shoot = '0; btn_stop = '0; shoot_ack = '0;
    tick(3);
    reset = 1'b0;
    tick(1);
    checks++;
    if (speed_data !== 64'd0) begin failures++; $display("FAIL reset_speed got=%h want=%h", speed_data, 64'd0); end
    checks++;
    if (shoot_req !== 2'b00) begin failures++; $display("FAIL reset_req got=%b want=00", shoot_req); end
    checks++;
    if (cooling !== 2'b00) begin failures++; $display("FAIL reset_cool got=%b want=00", cooling); end
  endtask

  // Right held 20 cycles on P0: speed flips to +1 exactly on edge 8.
  task automatic test_latency();
    btn_right[0] = 1'b1;
    tick(7);
    checks++;
    if (speed_data[31:0] !== 32'd0) begin failures++; $display("FAIL latency_edge7 got=%h want=%h", speed_data[31:0], 32'd0); end
    tick(1);
    checks++;
    if (speed_data[31:0] !== 32'd1) begin failures++; $display("FAIL latency_edge8 got=%h want=%h", speed_data[31:0], 32'd1); end
    checks++;
    if (speed_data[63:32] !== 32'd0) begin failures++; $display("FAIL latency_p1 got=%h want=%h", speed_data[63:32], 32'd0); end
    tick(12);
    btn_right[0] = 1'b0;
    tick(10);
    checks++;
    if (speed_data[31:0] !== 32'd1) begin failures++; $display("FAIL latency_hold got=%h want=%h", speed_data[31:0], 32'd1); end
  endtask

  // A 3-cycle glitch is shorter than the debounce window; a stable press is not.
  task automatic test_glitch();
    btn_left[0] = 1'b1;
    tick(3);
    btn_left[0] = 1'b0;
    tick(12);
    checks++;
    if (speed_data[31:0] !== 32'd1) begin failures++; $display("FAIL glitch_ignored got=%h want=%h", speed_data[31:0], 32'd1); end
    btn_left[0] = 1'b1;
    tick(8);
    checks++;
    if (speed_data[31:0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL left_stable got=%h want=%h", speed_data[31:0], 32'hFFFF_FFFF); end
    btn_left[0] = 1'b0;
    tick(10);
  endtask

  task automatic test_left_right_stop();
    btn_right[0] = 1'b1;
    tick(8);
    btn_right[0] = 1'b0;
    tick(10);
    checks++;
    if (speed_data[31:0] !== 32'd1) begin failures++; $display("FAIL right_again got=%h want=%h", speed_data[31:0], 32'd1); end
    btn_left[0] = 1'b1; btn_right[0] = 1'b1;
    tick(8);
    btn_left[0] = 1'b0; btn_right[0] = 1'b0;
    tick(10);
    checks++;
    if (speed_data[31:0] !== 32'd1) begin failures++; $display("FAIL left_right_hold got=%h want=%h", speed_data[31:0], 32'd1); end
    btn_stop[0] = 1'b1;
    tick(8);
    checks++;
    if (speed_data[31:0] !== 32'd0) begin failures++; $display("FAIL stop_zero got=%h want=%h", speed_data[31:0], 32'd0); end
    btn_stop[0] = 1'b0;
    tick(10);
  endtask

  task automatic test_shoot_cooldown();
    int cnt;
    btn_shoot[1] = 1'b1;
    tick(7);
    checks++;
    if (shoot_req[1] !== 1'b0) begin failures++; $display("FAIL shoot_edge7 got=%b want=0", shoot_req[1]); end
    tick(1);
    checks++;
    if (shoot_req[1] !== 1'b1) begin failures++; $display("FAIL shoot_armed got=%b want=1", shoot_req[1]); end
    btn_shoot[1] = 1'b0;
    tick(10);
    checks++;
    if (shoot_req[1] !== 1'b1) begin failures++; $display("FAIL shoot_held got=%b want=1", shoot_req[1]); end
    shoot_ack[1] = 1'b1;
    tick(1);
    shoot_ack[1] = 1'b0;
    checks++;
    if (shoot_req[1] !== 1'b0 || cooling[1] !== 1'b1) begin
      failures++; $display("FAIL ack_enter_cool got=req%b/cool%b want=req0/cool1", shoot_req[1], cooling[1]);
    end
    // Press shoot during cooldown; its pulse arrives mid-cooldown and must drop.
    btn_shoot[1] = 1'b1;
    cnt = 0;
    while (cooling[1] === 1'b1 && cnt < 100) begin
      tick(1);
      cnt++;
      if (cnt == 6) btn_shoot[1] = 1'b0;
    end
    checks++;
    if (cnt != 32) begin failures++; $display("FAIL cool_length got=%0d want=%0d", cnt, 32); end
    tick(10);
    checks++;
    if (shoot_req[1] !== 1'b0) begin failures++; $display("FAIL shoot_dropped got=%b want=0", shoot_req[1]); end
    btn_shoot[1] = 1'b1;
    tick(8);
    checks++;
    if (shoot_req[1] !== 1'b1) begin failures++; $display("FAIL shoot_rearm got=%b want=1", shoot_req[1]); end
    btn_shoot[1] = 1'b0;
    tick(10);
  endtask

  // Entered with P1 ARMED from the previous task.
  task automatic test_cancel_and_ack_stop();
    int cnt;
    btn_stop[1] = 1'b1;
    tick(8);
    checks++;
    if (shoot_req[1] !== 1'b0 || cooling[1] !== 1'b0) begin
      failures++; $display("FAIL stop_cancel got=req%b/cool%b want=req0/cool0", shoot_req[1], cooling[1]);
    end
    btn_stop[1] = 1'b0;
    tick(10);
    shoot_ack[1] = 1'b1;
    tick(1);
    shoot_ack[1] = 1'b0;
    checks++;
    if (cooling[1] !== 1'b0) begin failures++; $display("FAIL ack_idle_ignored got=%b want=0", cooling[1]); end
    btn_shoot[1] = 1'b1;
    tick(8);
    btn_shoot[1] = 1'b0;
    tick(10);
    // Stop pulse is consumed on the 8th edge after press; ack lands on that edge.
    btn_stop[1] = 1'b1;
    tick(7);
    shoot_ack[1] = 1'b1;
    tick(1);
    shoot_ack[1] = 1'b0;
    checks++;
    if (shoot_req[1] !== 1'b0 || cooling[1] !== 1'b1) begin
      failures++; $display("FAIL ack_beats_stop got=req%b/cool%b want=req0/cool1", shoot_req[1], cooling[1]);
    end
    btn_stop[1] = 1'b0;
    cnt = 0;
    while (cooling[1] === 1'b1 && cnt < 100) begin
      tick(1);
      cnt++;
    end
    checks++;
    if (cnt != 32) begin failures++; $display("FAIL ack_stop_cool_length got=%0d want=%0d", cnt, 32); end
    tick(5);
  endtask

  task automatic test_enable_and_reset();
    btn_left[0] = 1'b1;
    tick(8);
    btn_left[0] = 1'b0;
    tick(10);
    btn_shoot[0] = 1'b1;
    tick(8);
    btn_shoot[0] = 1'b0;
    tick(10);
    checks++;
    if (shoot_req[0] !== 1'b1 || speed_data[31:0] !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL pre_enable got=req%b/spd%h want=req1/spd%h", shoot_req[0], speed_data[31:0], 32'hFFFF_FFFF);
    end
    enable = 1'b0;
    tick(1);
    checks++;
    if (shoot_req[0] !== 1'b0 || speed_data[31:0] !== 32'd0) begin
      failures++; $display("FAIL enable_clear got=req%b/spd%h want=req0/spd%h", shoot_req[0], speed_data[31:0], 32'd0);
    end
    btn_right[0] = 1'b1;
    tick(12);
    enable = 1'b1;
    tick(10);
    checks++;
    if (speed_data[31:0] !== 32'd0) begin failures++; $display("FAIL held_across_enable got=%h want=%h", speed_data[31:0], 32'd0); end
    btn_right[0] = 1'b0;
    tick(10);
    // Put some state in every output, then reset in the middle of cooldown.
    btn_right[0] = 1'b1;
    tick(8);
    btn_right[0] = 1'b0;
    tick(10);
    btn_shoot[1] = 1'b1;
    tick(8);
    btn_shoot[1] = 1'b0;
    tick(10);
    shoot_ack[1] = 1'b1;
    tick(1);
    shoot_ack[1] = 1'b0;
    tick(5);
    checks++;
    if (cooling[1] !== 1'b1 || speed_data[31:0] !== 32'd1) begin
      failures++; $display("FAIL pre_reset got=cool%b/spd%h want=cool1/spd%h", cooling[1], speed_data[31:0], 32'd1);
    end
    reset = 1'b1;
    tick(1);
    checks++;
    if (speed_data !== 64'd0 || shoot_req !== 2'b00 || cooling !== 2'b00) begin
      failures++; $display("FAIL mid_cool_reset got=spd%h/req%b/cool%b want=all zero", speed_data, shoot_req, cooling);
    end
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_left_right_stop();
    test_shoot_cooldown();
    test_cancel_and_ack_stop();
    test_enable_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
